round_sequencer: RTL and testbench
==================================

# round_sequencer

Top-level round controller for the two-game console. It sequences a round:
- level regeneration handshake with the ball engine;
- a visible countdown;
- run, pause and the win/lose result hold;
- rating tracking.

It sits between the buttons/switches, both game engines and the banner/quad-display path. It drives the engines' pause and regenerate inputs and the banner selection.

## Interface
Parameters:
- TICKS_PER_SEC, 50_000_000: clk cycles per countdown/hold second
- COUNTDOWN_SEC, 3: countdown length in seconds, 1..15
- RESULT_HOLD_SEC, 2: win/lose banner hold in seconds, ≥1
- REGEN_TIMEOUT, 1_000_000: cycles to wait for i_ready before re-issuing regenerate
- RATING_WIDTH, 8: rating counter width
- NUM_IMAGES, 4: banner count; image index width is $clog2(NUM_IMAGES)

Ports:
- clk  in  1  system clock (single clock domain)
- rst  in  1  synchronous, active-high reset
- i_start  in  1  start button (level; edge-detected internally)
- i_pause  in  1  pause switch (level)
- i_win  in  1  ball game won
- i_lose1  in  1  ball game lost
- i_lose2  in  1  obstacle game lost
- i_ready  in  1  safe zone generated (level)
- o_regenerate_level  out  1  one-cycle regenerate pulse
- o_game_running  out  1  engines run; 0 = engines paused, banner shown
- o_image_number  out  $clog2(NUM_IMAGES)  banner index
- o_current_rating  out  RATING_WIDTH  rating for quad display
- o_countdown  out  4  remaining countdown seconds; 0 outside COUNTDOWN

## Operation
- Images: 0 TITLE, 1 READY, 2 WIN, 3 LOSE.
- States:
  - IDLE: image TITLE, or the last result.
  - REGEN
  - COUNTDOWN: image READY.
  - RUN
  - PAUSE: image READY.
  - RESULT: image WIN/LOSE.
- IDLE, start edge:
  - Clear the rating to 0.
  - Go to REGEN and pulse o_regenerate_level.
- REGEN:
  - i_ready high → COUNTDOWN, with the count loaded to COUNTDOWN_SEC.
  - REGEN_TIMEOUT cycles without i_ready → pulse regenerate again and restart the timeout.
- COUNTDOWN:
  - Each second tick decrements the count.
  - A tick while the count is 1 → RUN, with o_countdown = 0.
  - i_pause high freezes the count and the tick divider.
- RUN:
  - o_game_running = 1.
  - i_lose1 or i_lose2 → RESULT(LOSE). Lose has priority over a simultaneous i_win.
  - Otherwise i_win → RESULT(WIN), and the rating increments, saturating at all-ones.
  - Else i_pause → PAUSE.
- PAUSE:
  - i_win and i_lose* are ignored.
  - i_pause low → RUN.
- RESULT:
  - Hold for RESULT_HOLD_SEC ticks.
  - WIN then → REGEN (next level; regenerate pulse, rating kept).
  - LOSE then → IDLE showing LOSE, rating kept for display until the next start.
- Start edges outside IDLE are ignored.

## Timing
- All outputs are registered.
- Reset values:
  - State IDLE.
  - o_regenerate_level 0.
  - o_game_running 0.
  - o_image_number 0.
  - o_current_rating 0.
  - o_countdown 0.
- Start edge detection:
  - Registered i_start compared with its previous value.
  - i_start held high through reset does not produce an edge.
  - A rising edge sampled at cycle N gives o_regenerate_level high at cycle N+1 for exactly one cycle, together with the REGEN state.
- The tick divider restarts from 0 on entry to COUNTDOWN and RESULT, so the first second is always a full TICKS_PER_SEC cycles.
- Win/lose/ready sampled at cycle N: the state change and outputs appear at N+1.
- Entry into RUN and into PAUSE each take effect one cycle after the qualifying input.
- Rating and the RESULT image update in the same cycle as the RUN→RESULT transition.
- rst mid-round returns everything to reset values on the next edge. No regenerate pulse is emitted from reset.

## Configuration
- ROUND_SEQ_RESUME_COUNTDOWN_EN defined:
  - PAUSE→RUN is replaced by PAUSE→COUNTDOWN, reloading COUNTDOWN_SEC.
  - The pause release is then shown as a full countdown before play resumes.
- Undefined: immediate PAUSE→RUN.

## Structure
- Shared package game_pkg:
  - banner image enum (IMG_TITLE, IMG_READY, IMG_WIN, IMG_LOSE);
  - round state enum;
  - result type (WIN/LOSE).
- One sub-module, sec_tick_gen:
  - parameter TICKS_PER_SEC;
  - inputs clear and enable;
  - output one-cycle tick.
  - Used for the countdown and for the result hold.

## Test plan
- Reset with i_start held high, then release and press → exactly one o_regenerate_level pulse one cycle after the edge. Rating 0, image TITLE before the press.
- i_ready withheld, TICKS_PER_SEC=10, REGEN_TIMEOUT=20 → regenerate pulses 20 cycles apart. Raise i_ready → o_countdown shows 3,2,1 at 10-cycle spacing, then o_game_running=1.
- In RUN assert i_win and i_lose2 in the same cycle → image LOSE, rating unchanged. After 2 ticks → IDLE with image LOSE.
- Three consecutive wins starting from rating 254 (RATING_WIDTH=8) → rating 255, 255, 255. Each win gives WIN for 2 ticks, then a regenerate pulse.
- In COUNTDOWN at count 2, hold i_pause 50 cycles → o_countdown stays 2, then resumes with a full second.
- PAUSE release:
  - With the macro undefined, dropping i_pause gives o_game_running=1 next cycle.
  - With the macro defined, dropping i_pause gives o_countdown=3 and o_game_running=0.

Source files
------------

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
//   Shared types for the two-game console round controller.
//   - image_e  : banner image index shown on the banner/quad-display path
//   - state_e  : round sequencer state
//   - result_e : outcome of a finished round
// -----------------------------------------------------------------------------
package game_pkg;

   typedef enum logic [1:0] {
      IMG_TITLE = 2'd0,
      IMG_READY = 2'd1,
      IMG_WIN   = 2'd2,
      IMG_LOSE  = 2'd3
   } image_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_REGEN     = 3'd1,
      ST_COUNTDOWN = 3'd2,
      ST_RUN       = 3'd3,
      ST_PAUSE     = 3'd4,
      ST_RESULT    = 3'd5
   } state_e;

   typedef enum logic {
      RES_WIN  = 1'b0,
      RES_LOSE = 1'b1
   } result_e;

   // Width of the visible countdown digit.
   localparam int COUNT_WIDTH = 4;

endpackage

// File: rtl/sec_tick_gen.sv
// -----------------------------------------------------------------------------
// sec_tick_gen
//   Divides clk down to a one-cycle tick every TICKS_PER_SEC enabled cycles.
//   Used by the round sequencer for the countdown and the result hold.
//
// Ports
//   clk     in   system clock
//   rst     in   synchronous, active-high reset
//   clear   in   hold the divider at 0 (the next second starts in full)
//   enable  in   advance the divider; low freezes it where it is
//   tick    out  high for one cycle on the last cycle of each second
// -----------------------------------------------------------------------------
module sec_tick_gen #(
   parameter int TICKS_PER_SEC = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

   logic [CW-1:0] cnt;

   // Combinational so the consumer sees the tick in the same cycle the
   // divider wraps; the consumer registers everything it derives from it.
   assign tick = enable && !clear && (cnt == LAST);

   // NOTE: sequential state is always written with non-blocking assignments
   // so every flop samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= tick ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/round_sequencer.sv
// -----------------------------------------------------------------------------
// round_sequencer
//   Top-level round controller for the two-game console. Sequences a round:
//   level regeneration handshake, visible countdown, run/pause, win/lose
//   banner hold, and rating tracking. All outputs are registered.
//
// Configuration
//   ROUND_SEQ_RESUME_COUNTDOWN_EN : when defined, releasing pause replays a
//   full countdown before play resumes; otherwise play resumes immediately.
//
// Ports
//   clk                 in   system clock
//   rst                 in   synchronous, active-high reset
//   i_start             in   start button level (edge-detected here)
//   i_pause             in   pause switch level
//   i_win               in   ball game won
//   i_lose1             in   ball game lost
//   i_lose2             in   obstacle game lost
//   i_ready             in   safe zone generated (level)
//   o_regenerate_level  out  one-cycle regenerate request to the ball engine
//   o_game_running      out  1 = engines run, 0 = engines paused/banner shown
//   o_image_number      out  banner index (TITLE/READY/WIN/LOSE)
//   o_current_rating    out  rating for the quad display
//   o_countdown         out  remaining countdown seconds, 0 outside countdown
// -----------------------------------------------------------------------------
module round_sequencer
   import game_pkg::*;
#(
   parameter int TICKS_PER_SEC   = 50_000_000,
   parameter int COUNTDOWN_SEC   = 3,
   parameter int RESULT_HOLD_SEC = 2,
   parameter int REGEN_TIMEOUT   = 1_000_000,
   parameter int RATING_WIDTH    = 8,
   parameter int NUM_IMAGES      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_start,
   input  logic                          i_pause,
   input  logic                          i_win,
   input  logic                          i_lose1,
   input  logic                          i_lose2,
   input  logic                          i_ready,
   output logic                          o_regenerate_level,
   output logic                          o_game_running,
   output logic [$clog2(NUM_IMAGES)-1:0] o_image_number,
   output logic [RATING_WIDTH-1:0]       o_current_rating,
   output logic [3:0]                    o_countdown
);

   localparam int IMG_W = $clog2(NUM_IMAGES);
   localparam int RCW   = (REGEN_TIMEOUT > 1) ? $clog2(REGEN_TIMEOUT) : 1;
   localparam int HCW   = (RESULT_HOLD_SEC > 1) ? $clog2(RESULT_HOLD_SEC) : 1;

   localparam logic [RCW-1:0]         REGEN_LAST = RCW'(REGEN_TIMEOUT - 1);
   localparam logic [HCW-1:0]         HOLD_LAST  = HCW'(RESULT_HOLD_SEC - 1);
   localparam logic [COUNT_WIDTH-1:0] COUNT_LOAD = COUNT_WIDTH'(COUNTDOWN_SEC);

   // Registered state and outputs (_q) with their next values (_d).
   state_e                   state_q, state_d;
   result_e                  result_q, result_d;
   image_e                   image_q, image_d;
   logic [COUNT_WIDTH-1:0]   count_q, count_d;
   logic [HCW-1:0]           hold_q, hold_d;
   logic [RCW-1:0]           regen_cnt_q, regen_cnt_d;
   logic [RATING_WIDTH-1:0]  rating_q, rating_d;
   logic                     regen_pulse_q, regen_pulse_d;
   logic                     running_q;

   logic start_q, start_prev_q, start_edge;
   logic tick, tick_clear, tick_enable;

   assign start_edge = start_q && !start_prev_q;

   // The divider only runs in the two timed states; holding it cleared
   // everywhere else guarantees a full first second on entry.
   assign tick_clear  = !(state_q == ST_COUNTDOWN || state_q == ST_RESULT);
   assign tick_enable = (state_q == ST_COUNTDOWN && !i_pause) ||
                        (state_q == ST_RESULT);

   sec_tick_gen #(
      .TICKS_PER_SEC (TICKS_PER_SEC)
   ) u_sec_tick (
      .clk    (clk),
      .rst    (rst),
      .clear  (tick_clear),
      .enable (tick_enable),
      .tick   (tick)
   );

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      result_d      = result_q;
      image_d       = image_q;
      count_d       = '0;
      hold_d        = hold_q;
      regen_cnt_d   = '0;
      rating_d      = rating_q;
      regen_pulse_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // Image stays TITLE or the last result until the next start.
            if (start_edge) begin
               rating_d      = '0;
               state_d       = ST_REGEN;
               regen_pulse_d = 1'b1;
               image_d       = IMG_READY;
            end
         end

         ST_REGEN: begin
            image_d = IMG_READY;
            if (i_ready) begin
               state_d = ST_COUNTDOWN;
               count_d = COUNT_LOAD;
            end else if (regen_cnt_q == REGEN_LAST) begin
               // Ball engine never answered: ask again, restart the wait.
               regen_pulse_d = 1'b1;
            end else begin
               regen_cnt_d = regen_cnt_q + RCW'(1);
            end
         end

         ST_COUNTDOWN: begin
            image_d = IMG_READY;
            count_d = count_q;
            if (tick) begin
               if (count_q == COUNT_WIDTH'(1)) begin
                  state_d = ST_RUN;
                  count_d = '0;
               end else begin
                  count_d = count_q - COUNT_WIDTH'(1);
               end
            end
         end

         ST_RUN: begin
            if (i_lose1 || i_lose2) begin
               state_d  = ST_RESULT;
               result_d = RES_LOSE;
               image_d  = IMG_LOSE;
               hold_d   = '0;
            end else if (i_win) begin
               state_d  = ST_RESULT;
               result_d = RES_WIN;
               image_d  = IMG_WIN;
               hold_d   = '0;
               if (rating_q != '1) begin
                  rating_d = rating_q + RATING_WIDTH'(1);
               end
            end else if (i_pause) begin
               state_d = ST_PAUSE;
               image_d = IMG_READY;
            end
         end

         ST_PAUSE: begin
            image_d = IMG_READY;
            if (!i_pause) begin
`ifdef ROUND_SEQ_RESUME_COUNTDOWN_EN
               state_d = ST_COUNTDOWN;
               count_d = COUNT_LOAD;
`else
               state_d = ST_RUN;
`endif
            end
         end

         ST_RESULT: begin
            if (tick) begin
               if (hold_q == HOLD_LAST) begin
                  hold_d = '0;
                  if (result_q == RES_WIN) begin
                     state_d       = ST_REGEN;
                     regen_pulse_d = 1'b1;
                     image_d       = IMG_READY;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  hold_d = hold_q + HCW'(1);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         result_q      <= RES_WIN;
         image_q       <= IMG_TITLE;
         count_q       <= '0;
         hold_q        <= '0;
         regen_cnt_q   <= '0;
         rating_q      <= '0;
         regen_pulse_q <= 1'b0;
         running_q     <= 1'b0;
         // Both history bits read as "already high" so a button held through
         // reset cannot look like a fresh press afterwards.
         start_q       <= 1'b1;
         start_prev_q  <= 1'b1;
      end else begin
         state_q       <= state_d;
         result_q      <= result_d;
         image_q       <= image_d;
         count_q       <= count_d;
         hold_q        <= hold_d;
         regen_cnt_q   <= regen_cnt_d;
         rating_q      <= rating_d;
         regen_pulse_q <= regen_pulse_d;
         running_q     <= (state_d == ST_RUN);
         start_q       <= i_start;
         start_prev_q  <= start_q;
      end
   end

   assign o_regenerate_level = regen_pulse_q;
   assign o_game_running     = running_q;
   assign o_image_number     = IMG_W'(image_q);
   assign o_current_rating   = rating_q;
   assign o_countdown        = count_q;

endmodule

// File: tb/tb_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_round_sequencer
//   Self-checking bench for round_sequencer with short timing parameters.
//   A behavioural model (elapsed-cycle arithmetic per round phase) is stepped
//   on every clock edge and compared with the DUT outputs; directed sequences
//   and a table of RUN-state input combinations add hand-computed checks.
//   Honours ROUND_SEQ_RESUME_COUNTDOWN_EN for the pause-release behaviour.
// -----------------------------------------------------------------------------
module tb_round_sequencer;

   localparam int TPS  = 10;
   localparam int CDS  = 3;
   localparam int HOLD = 2;
   localparam int RTO  = 20;
   localparam int RW   = 8;
   localparam int NI   = 4;

   localparam int IMG_TITLE = 0;
   localparam int IMG_READY = 1;
   localparam int IMG_WIN   = 2;
   localparam int IMG_LOSE  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic i_start = 1'b0, i_pause = 1'b0, i_win = 1'b0;
   logic i_lose1 = 1'b0, i_lose2 = 1'b0, i_ready = 1'b0;
   logic          o_regenerate_level, o_game_running;
   logic [1:0]    o_image_number;
   logic [RW-1:0] o_current_rating;
   logic [3:0]    o_countdown;

   round_sequencer #(
      .TICKS_PER_SEC   (TPS),
      .COUNTDOWN_SEC   (CDS),
      .RESULT_HOLD_SEC (HOLD),
      .REGEN_TIMEOUT   (RTO),
      .RATING_WIDTH    (RW),
      .NUM_IMAGES      (NI)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .i_start            (i_start),
      .i_pause            (i_pause),
      .i_win              (i_win),
      .i_lose1            (i_lose1),
      .i_lose2            (i_lose2),
      .i_ready            (i_ready),
      .o_regenerate_level (o_regenerate_level),
      .o_game_running     (o_game_running),
      .o_image_number     (o_image_number),
      .o_current_rating   (o_current_rating),
      .o_countdown        (o_countdown)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: round phase plus elapsed-cycle counters.
   // ---------------------------------------------------------------------------
   localparam int M_IDLE = 0, M_REGEN = 1, M_CD = 2, M_RUN = 3, M_PAUSE = 4, M_RES = 5;

   int m_mode   = M_IDLE;
   int m_age    = 0;     // edges spent waiting in REGEN since the last request
   int m_el     = 0;     // unpaused edges spent in countdown / result
   int m_rating = 0;
   int m_image  = IMG_TITLE;
   bit m_won    = 1'b0;
   bit m_pulse  = 1'b0;
   bit h1 = 1'b1, h2 = 1'b1;  // start button as seen one and two edges ago

   task automatic model_edge();
      bit pressed;
      if (rst) begin
         m_mode = M_IDLE; m_rating = 0; m_image = IMG_TITLE; m_pulse = 1'b0;
         h1 = 1'b1; h2 = 1'b1;
         return;
      end
      pressed = h1 && !h2;
      h2 = h1;
      h1 = i_start;
      m_pulse = 1'b0;
      case (m_mode)
         M_IDLE: if (pressed) begin
            m_rating = 0; m_mode = M_REGEN; m_age = 0; m_pulse = 1'b1; m_image = IMG_READY;
         end
         M_REGEN: if (i_ready) begin
            m_mode = M_CD; m_el = 0;
         end else begin
            m_age++;
            if (m_age % RTO == 0) m_pulse = 1'b1;
         end
         M_CD: if (!i_pause) begin
            m_el++;
            if (m_el == CDS * TPS) m_mode = M_RUN;
         end
         M_RUN: if (i_lose1 || i_lose2) begin
            m_mode = M_RES; m_won = 1'b0; m_image = IMG_LOSE; m_el = 0;
         end else if (i_win) begin
            m_mode = M_RES; m_won = 1'b1; m_image = IMG_WIN; m_el = 0;
            if (m_rating < (1 << RW) - 1) m_rating++;
         end else if (i_pause) begin
            m_mode = M_PAUSE;
         end
         M_PAUSE: if (!i_pause) begin
`ifdef ROUND_SEQ_RESUME_COUNTDOWN_EN
            m_mode = M_CD; m_el = 0;
`else
            m_mode = M_RUN;
`endif
         end
         M_RES: begin
            m_el++;
            if (m_el == HOLD * TPS) begin
               if (m_won) begin
                  m_mode = M_REGEN; m_age = 0; m_pulse = 1'b1; m_image = IMG_READY;
               end else begin
                  m_mode = M_IDLE;
               end
            end
         end
         default: m_mode = M_IDLE;
      endcase
   endtask

   task automatic model_compare();
      int exp_count;
      exp_count = (m_mode == M_CD) ? CDS - m_el / TPS : 0;
      check("model_regen",     o_regenerate_level, m_pulse);
      check("model_running",   o_game_running,     (m_mode == M_RUN) ? 1 : 0);
      check("model_rating",    o_current_rating,   m_rating);
      check("model_countdown", o_countdown,        exp_count);
      if (m_mode == M_IDLE || m_mode == M_CD || m_mode == M_PAUSE || m_mode == M_RES)
         check("model_image", o_image_number, (m_mode == M_IDLE || m_mode == M_RES) ? m_image : IMG_READY);
   endtask

   // One clock: inputs are already stable, sample outputs 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      model_compare();
   endtask

   task automatic clear_inputs();
      i_win = 1'b0; i_lose1 = 1'b0; i_lose2 = 1'b0; i_pause = 1'b0; i_ready = 1'b0;
   endtask

   // Drive the console into RUN from wherever it is, bounded.
   task automatic go_to_run();
      int n;
      n = 0;
      clear_inputs();
      i_ready = 1'b1;
      while (!o_game_running && n < 300) begin
         i_start = n[0];
         step();
         n++;
      end
      i_start = 1'b0;
      i_ready = 1'b0;
      check("reach_run", o_game_running, 1);
   endtask

   // One won round from RUN back to RUN.
   task automatic win_round(input bit verbose, input int exp_rating);
      i_win = 1'b1;
      step();
      i_win = 1'b0;
      if (verbose) begin
         check("sat_image_win", o_image_number, IMG_WIN);
         check("sat_rating",    o_current_rating, exp_rating);
      end
      repeat (HOLD * TPS - 1) step();
      if (verbose) check("sat_hold_no_pulse", o_regenerate_level, 0);
      step();
      if (verbose) check("sat_regen_pulse", o_regenerate_level, 1);
      i_ready = 1'b1;
      step();
      i_ready = 1'b0;
      repeat (CDS * TPS) step();
      if (verbose) check("sat_back_run", o_game_running, 1);
   endtask

   typedef struct {
      string name;
      bit    win, lose1, lose2, pause;
      bit    exp_running;
      bit    chk_image;
      int    exp_image;
      int    rating_inc;
      bit    lost;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int cur_rating;
      bit last_lost;

      vecs[0] = '{"none",      0,0,0,0, 1, 0, 0,         0, 0};
      vecs[1] = '{"win",       1,0,0,0, 0, 1, IMG_WIN,   1, 0};
      vecs[2] = '{"lose1",     0,1,0,0, 0, 1, IMG_LOSE,  0, 1};
      vecs[3] = '{"lose2",     0,0,1,0, 0, 1, IMG_LOSE,  0, 1};
      vecs[4] = '{"win_lose1", 1,1,0,0, 0, 1, IMG_LOSE,  0, 1};
      vecs[5] = '{"pause",     0,0,0,1, 0, 1, IMG_READY, 0, 0};
      vecs[6] = '{"win_pause", 1,0,0,1, 0, 1, IMG_WIN,   1, 0};
      vecs[7] = '{"lose_paus", 0,0,1,1, 0, 1, IMG_LOSE,  0, 1};
      vecs[8] = '{"all",       1,1,1,1, 0, 1, IMG_LOSE,  0, 1};

      // --- Reset with start held high, then a clean press -----------------
      rst = 1'b1; i_start = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      repeat (3) step();
      check("rst_regen",     o_regenerate_level, 0);
      check("rst_running",   o_game_running, 0);
      check("rst_image",     o_image_number, IMG_TITLE);
      check("rst_rating",    o_current_rating, 0);
      check("rst_countdown", o_countdown, 0);
      i_start = 1'b0;
      repeat (2) step();
      i_start = 1'b1;
      step();
      check("press_early", o_regenerate_level, 0);
      step();
      check("press_pulse", o_regenerate_level, 1);

      // --- Regenerate timeout, then countdown -----------------------------
      for (int i = 1; i <= RTO; i++) begin
         step();
         check("regen_timeout", o_regenerate_level, (i == RTO) ? 1 : 0);
      end
      i_ready = 1'b1;
      step();
      i_ready = 1'b0;
      check("cd_load", o_countdown, 3);
      check("cd_image", o_image_number, IMG_READY);
      for (int j = 1; j <= CDS * TPS; j++) begin
         step();
         if (j == 9)  check("cd_3_hold", o_countdown, 3);
         if (j == 10) check("cd_2", o_countdown, 2);
         if (j == 20) check("cd_1", o_countdown, 1);
         if (j == 29) check("cd_not_yet_run", o_game_running, 0);
      end
      check("cd_done_zero", o_countdown, 0);
      check("cd_done_run", o_game_running, 1);

      // --- Simultaneous win and lose2 -------------------------------------
      i_win = 1'b1; i_lose2 = 1'b1;
      step();
      clear_inputs();
      check("winlose_image",  o_image_number, IMG_LOSE);
      check("winlose_rating", o_current_rating, 0);
      check("winlose_run",    o_game_running, 0);
      repeat (HOLD * TPS) step();
      check("idle_lose_image", o_image_number, IMG_LOSE);
      i_start = 1'b0;
      step();
      i_start = 1'b1;
      repeat (2) step();
      check("idle_restart_pulse", o_regenerate_level, 1);

      // --- Pause during countdown -----------------------------------------
      i_ready = 1'b1;
      step();
      i_ready = 1'b0;
      repeat (TPS) step();
      check("cdp_at_2", o_countdown, 2);
      i_pause = 1'b1;
      repeat (50) step();
      check("cdp_frozen", o_countdown, 2);
      i_pause = 1'b0;
      repeat (TPS - 1) step();
      check("cdp_full_second", o_countdown, 2);
      step();
      check("cdp_resume_1", o_countdown, 1);
      repeat (TPS) step();
      check("cdp_run", o_game_running, 1);

      // --- Pause in RUN, win/lose ignored, release ------------------------
      i_pause = 1'b1;
      step();
      check("pause_running", o_game_running, 0);
      check("pause_image",   o_image_number, IMG_READY);
      i_win = 1'b1; i_lose1 = 1'b1;
      step();
      i_win = 1'b0; i_lose1 = 1'b0;
      step();
      check("pause_ignore_img", o_image_number, IMG_READY);
      check("pause_ignore_rat", o_current_rating, 0);
      i_pause = 1'b0;
      step();
`ifdef ROUND_SEQ_RESUME_COUNTDOWN_EN
      check("release_cd",      o_countdown, 3);
      check("release_running", o_game_running, 0);
      repeat (CDS * TPS) step();
      check("release_cd_run",  o_game_running, 1);
`else
      check("release_running", o_game_running, 1);
      check("release_cd_zero", o_countdown, 0);
`endif

      // --- Table of RUN-state input combinations --------------------------
      cur_rating = 0;
      last_lost  = 1'b0;
      foreach (vecs[k]) begin
         go_to_run();
         if (last_lost) cur_rating = 0;
         i_win = vecs[k].win; i_lose1 = vecs[k].lose1;
         i_lose2 = vecs[k].lose2; i_pause = vecs[k].pause;
         step();
         clear_inputs();
         check({"vec_run_", vecs[k].name}, o_game_running, vecs[k].exp_running);
         if (vecs[k].chk_image)
            check({"vec_img_", vecs[k].name}, o_image_number, vecs[k].exp_image);
         cur_rating += vecs[k].rating_inc;
         check({"vec_rat_", vecs[k].name}, o_current_rating, cur_rating);
         last_lost = vecs[k].lost;
      end

      // --- Rating saturation ----------------------------------------------
      go_to_run();
      if (last_lost) cur_rating = 0;
      while (cur_rating < 254) begin
         win_round(1'b0, 0);
         cur_rating++;
      end
      check("sat_pre", o_current_rating, 254);
      for (int w = 0; w < 3; w++) win_round(1'b1, 255);

      // --- Randomized run against the model -------------------------------
      for (int c = 0; c < 5000; c++) begin
         rst     = ($urandom_range(0, 499) == 0);
         i_start = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 19) == 0) i_pause = ~i_pause;
         i_win   = ($urandom_range(0, 14) == 0);
         i_lose1 = ($urandom_range(0, 39) == 0);
         i_lose2 = ($urandom_range(0, 39) == 0);
         i_ready = ($urandom_range(0, 9) == 0);
         step();
      end
      rst = 1'b0;
      clear_inputs();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
